// File: rtl/fifo_lane_sched_pkg.sv
// Shared types and sizing helpers for the fifo lane scheduler.
//
// Contents:
//   state_e          controller state (load / drain / done)
//   lane_width()     width of a lane index
//   cnt_width()      width of a per-lane fill counter (must hold 0..DEPTH)
//   drain_cnt_width  width of the drain step counter
//   drain_len()      number of drain cycles; depends on FIFO_LANE_SCHED_SKEW_EN
//
// Build option FIFO_LANE_SCHED_SKEW_EN: when defined, lanes drain diagonally
// skewed (DEPTH+LANES-1 cycles); when undefined all lanes drain together
// (DEPTH cycles).
package fifo_lane_sched_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned lane_width(int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned drain_cnt_width(int unsigned lanes, int unsigned depth);
    return $clog2(depth + lanes);
  endfunction

  function automatic int unsigned drain_len(int unsigned lanes, int unsigned depth);
`ifdef FIFO_LANE_SCHED_SKEW_EN
    return depth + lanes - 1;
`else
    // lanes is only meaningful for the skewed drain
    return depth + (lanes * 0);
`endif
  endfunction

  // Sizes for the default configuration (8 lanes x 8 entries).
  localparam int unsigned DefCntW   = cnt_width(8);
  localparam int unsigned DefDrainW = drain_cnt_width(8, 8);

endpackage

// File: rtl/fifo_lane_sched_if.sv
// Host write / drain-control / fifo-bank bundle for fifo_lane_sched.
//
// Signals:
//   wr_valid, wr_lane, wr_data, wr_ready  host write handshake
//   start, busy, done, err                drain control and status
//   fifo_en, fifo_d                       shift enable / shift-in data to the fifo bank
//   lane_valid                            per-lane valid strobe to the array
//
// Modports: master = host/wrapper side, slave = scheduler side.
interface fifo_lane_sched_if import fifo_lane_sched_pkg::*; #(
  parameter int unsigned LANES = 8,
  parameter int unsigned BITS  = 64
) ();

  localparam int unsigned LaneW = lane_width(LANES);

  logic             wr_valid;
  logic             wr_ready;
  logic [LaneW-1:0] wr_lane;
  logic [BITS-1:0]  wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [LANES-1:0] fifo_en;
  logic [BITS-1:0]  fifo_d;
  logic [LANES-1:0] lane_valid;

  modport master (
    output wr_valid, wr_lane, wr_data, start,
    input  wr_ready, busy, done, err, fifo_en, fifo_d, lane_valid
  );

  modport slave (
    input  wr_valid, wr_lane, wr_data, start,
    output wr_ready, busy, done, err, fifo_en, fifo_d, lane_valid
  );

endinterface

// File: rtl/fifo_lane_cnt.sv
// Saturating fill counter for one fifo lane.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         count one accepted write (ignored once full)
//   clr         clear to empty; wins over inc
//   full        count has reached DEPTH
module fifo_lane_cnt import fifo_lane_sched_pkg::*; #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == CntW'(DEPTH));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !full) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_lane_sched.sv
// Load / drain sequencer for a bank of LANES shift-register delay fifos.
//
// In load, host writes are steered into one lane at a time and per-lane fill
// levels are tracked. A start with every lane full drains the whole bank,
// shifting zeros in and raising per-lane valid strobes for the array; a start
// with any lane short is rejected and sets the sticky err flag.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         fifo_lane_sched_if.slave: host writes, start/busy/done/err,
//               fifo_en/fifo_d to the fifo bank, lane_valid to the array
//
// Build option FIFO_LANE_SCHED_SKEW_EN: diagonal-skewed drain (lane i shifts at
// steps i..i+DEPTH-1). Undefined: all lanes shift together for DEPTH steps.
module fifo_lane_sched import fifo_lane_sched_pkg::*; #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 64
) (
  input logic              clk,
  input logic              rst_n,
  fifo_lane_sched_if.slave bus
);

  localparam int unsigned LaneW    = lane_width(LANES);
  localparam int unsigned KW       = drain_cnt_width(LANES, DEPTH);
  localparam int unsigned DrainLen = drain_len(LANES, DEPTH);
  localparam int unsigned PadLanes = 2 ** LaneW;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          err_q, err_d;

  logic [LANES-1:0]    full;
  logic [LANES-1:0]    inc;
  logic                clr;
  logic [PadLanes-1:0] full_pad;
  logic                all_full;
  logic                wr_accept;
  logic                last_k;
  logic [LANES-1:0]    drain_mask;
  logic [31:0]         k_ext;

  // Unused lane codes (non power-of-two LANES) look full so they are never accepted.
  always_comb begin
    full_pad              = '1;
    full_pad[LANES-1:0]   = full;
  end

  assign all_full  = &full;
  assign wr_accept = bus.wr_valid && bus.wr_ready;
  assign last_k    = (k_q == KW'(DrainLen - 1));
  assign k_ext     = 32'(k_q);
  assign clr       = (state_q == StDone);

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      inc[i] = wr_accept && (bus.wr_lane == LaneW'(i));
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    fifo_lane_cnt #(
      .DEPTH (DEPTH)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[g]),
      .clr   (clr),
      .full  (full[g])
    );
  end

  // Lanes enabled at drain step k.
  always_comb begin
`ifdef FIFO_LANE_SCHED_SKEW_EN
    for (int i = 0; i < int'(LANES); i++) begin
      drain_mask[i] = (k_ext >= 32'(i)) && (k_ext < 32'(i) + 32'(DEPTH));
    end
`else
    drain_mask = (k_ext < 32'(DEPTH)) ? '1 : '0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next state. start is judged on registered fill levels only.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    unique case (state_q)
      StLoad: begin
        if (bus.start) begin
          if (all_full) begin
            state_d = StDrain;
            k_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (last_k) begin
          state_d = StDone;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        state_d = StLoad;
        k_d     = '0;
      end
      default: begin
        state_d = StLoad;
        k_d     = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    bus.wr_ready   = 1'b0;
    bus.fifo_en    = '0;
    bus.fifo_d     = '0;
    bus.lane_valid = '0;
    bus.busy       = (state_q == StDrain);
    bus.done       = (state_q == StDone);
    bus.err        = err_q;
    unique case (state_q)
      StLoad: begin
        bus.wr_ready = !full_pad[bus.wr_lane];
        if (bus.wr_valid && !full_pad[bus.wr_lane]) begin
          bus.fifo_en = LANES'(1) << bus.wr_lane;
          bus.fifo_d  = bus.wr_data;
        end
      end
      StDrain: begin
        bus.fifo_en    = drain_mask;
        bus.lane_valid = drain_mask;
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/fifo_lane_sched.md
Name: fifo_lane_sched

Overview:
- Controller that sequences a bank of LANES shift-register delay fifos (DEPTH entries × BITS each, with per-lane shift enable) feeding the systolic datapath.
- Load phase: steers host writes into individual lanes and tracks fill level per lane.
- Drain phase: shifts all lanes out in diagonal-skewed order, feeding zeros in, with per-lane valid strobes for the array.
- The fifo bank sits in the parent wrapper; this block drives only its en/d inputs.

Parameters:
- LANES, 8, number of fifo lanes (array rows).
- DEPTH, 8, entries per fifo lane; must match the fifo instances.
- BITS, 64, data width per entry.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  host write request.
- wr_ready  output  1  write can be accepted this cycle.
- wr_lane  input  $clog2(LANES)  target lane for the write.
- wr_data  input  BITS  write data.
- start  input  1  request drain; single-cycle pulse.
- busy  output  1  high while in DRAIN.
- done  output  1  one-cycle pulse when drain completes.
- err  output  1  sticky; start was rejected because the bank was not full.
- fifo_en  output  LANES  per-lane shift enable to the fifo bank.
- fifo_d  output  BITS  shared shift-in data to all lanes.
- lane_valid  output  LANES  the fifo q of that lane is valid for the array this cycle.

Behaviour:
- States: LOAD (reset state), DRAIN, DONE.
- Reset values:
  - state = LOAD; all fill counts = 0; drain counter = 0.
  - busy = 0, done = 0, err = 0.
  - fifo_en = 0, lane_valid = 0, fifo_d = 0.
- Counter widths:
  - fill count: $clog2(DEPTH+1) bits.
  - drain counter: $clog2(DEPTH+LANES) bits.
- LOAD:
  - wr_ready = (state==LOAD) && (cnt[wr_lane] != DEPTH). This is combinational from wr_lane and registered counts.
  - An accepted write (wr_valid && wr_ready) drives, in the same cycle:
    - fifo_en = one-hot(wr_lane);
    - fifo_d = wr_data;
    - cnt[wr_lane] increments at the clock edge.
  - With no accepted write: fifo_en = 0, fifo_d = 0.
  - lane_valid = 0 throughout LOAD.
  - A write to a full lane is not accepted (wr_ready = 0). No fifo_en is asserted and the count is unchanged.
  - start is evaluated against registered counts only. A same-cycle write that fills the last slot does not qualify that start.
  - start with all cnt == DEPTH: next state DRAIN, drain counter k = 0.
  - start with any lane not full: stay in LOAD; err set sticky until rst_n.
- DRAIN (busy = 1, wr_ready = 0, fifo_d = 0):
  - Lane i is enabled when i <= k < i+DEPTH; fifo_en[i] = lane_valid[i] = that condition.
  - The downstream array samples fifo q in the same cycle as the enable.
  - k increments every cycle. The last cycle is k = DEPTH+LANES-2, i.e. 15 cycles at defaults.
  - The next state after the last cycle is DONE.
  - start and wr_valid are ignored during DRAIN.
- DONE (one cycle):
  - done = 1; fifo_en = 0; all cnt cleared to 0.
  - Next state is LOAD. All fifos have shifted in zeros, so they are empty.
- Reset mid-operation: asynchronous return to the reset values from any state. The fifo bank shares rst_n, so contents are consistent.
- Outputs fifo_en, fifo_d, lane_valid and wr_ready are combinational from state/counters/inputs. busy and done decode from registered state.

Optional Feature:
- Macro: FIFO_LANE_SCHED_SKEW_EN.
- Defined: diagonal skew as above. Drain length is DEPTH+LANES-1 cycles.
- Undefined: all lanes are enabled together for k = 0..DEPTH-1. Drain length is DEPTH cycles; fifo_en = lane_valid = all-ones during DRAIN.

Decomposition:
- Package fifo_lane_sched_pkg:
  - state enum {LOAD, DRAIN, DONE};
  - function drain_len(LANES, DEPTH), which returns the skew-dependent length;
  - width helper constants for the counters.
- Sub-module fifo_lane_cnt:
  - one per lane via generate;
  - holds the saturating fill counter with inc and clr inputs;
  - provides a full flag.

Test Plan:
- Reset, then idle: wr_ready = 1, fifo_en = 0, busy = 0, done = 0, err = 0.
- 64 writes (8 per lane, data = lane*16+idx), then start:
  - busy for 15 cycles;
  - fifo_en[0] high at k = 0..7 and fifo_en[7] high at k = 7..14, with fifo_d = 0 throughout;
  - done pulses the next cycle, then wr_ready = 1.
- 8 writes to lane 3, then a 9th write to lane 3: wr_ready = 0, fifo_en = 0, cnt[3] stays 8. A write to lane 4 in the next cycle is accepted.
- Lane 5 holding 7 entries, start: err = 1, state stays LOAD. A further write to lane 5 is accepted; a second start then enters DRAIN with err still 1.
- rst_n asserted at drain k = 4: all outputs 0 immediately. After release, state is LOAD, counts are 0, wr_ready = 1.
- FIFO_LANE_SCHED_SKEW_EN undefined, full bank, start: fifo_en = 8'hFF for exactly 8 cycles, done on the 9th cycle.
